// File: rtl/cfu_mac_pkg.sv
// Shared constants and types for the CFU MAC sequencer.
//   - opcode values decoded from cmd_payload_function_id[9:3]
//   - sequencer state enum
//   - lane and offset widths of the 4-lane signed int8 MAC datapath
package cfu_mac_pkg;

  localparam int unsigned LANE_W    = 8;
  localparam int unsigned OFF_W     = 16;
  localparam int unsigned NUM_LANES = 4;
  localparam int unsigned OP_W      = 7;

  localparam logic [OP_W-1:0] OP_SET_OFF = 7'd0;
  localparam logic [OP_W-1:0] OP_WR_IN   = 7'd1;
  localparam logic [OP_W-1:0] OP_WR_FLT  = 7'd2;
  localparam logic [OP_W-1:0] OP_RUN     = 7'd3;

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    DRAIN,
    RESP
  } state_e;

endpackage

// File: rtl/simd_mac4.sv
// Combinational 4-lane signed int8 multiply with per-operand offsets.
// Ports:
//   in_word    - four packed signed int8 input lanes
//   flt_word   - four packed signed int8 filter lanes
//   input_off  - signed 16-bit offset added to every input lane
//   filter_off - signed 16-bit offset added to every filter lane
//   lane_sum   - sum of the four lane products, truncated to 32 bits
module simd_mac4
  import cfu_mac_pkg::*;
(
  input  logic [31:0]      in_word,
  input  logic [31:0]      flt_word,
  input  logic [OFF_W-1:0] input_off,
  input  logic [OFF_W-1:0] filter_off,
  output logic [31:0]      lane_sum
);

  localparam int unsigned OpW   = OFF_W + 1;
  localparam int unsigned ProdW = 2 * OpW;

  logic signed [OpW-1:0] in_op  [NUM_LANES];
  logic signed [OpW-1:0] flt_op [NUM_LANES];
  logic        [31:0]    prod   [NUM_LANES];

  always_comb begin
    lane_sum = '0;
    for (int i = 0; i < NUM_LANES; i++) begin
      in_op[i]  = OpW'($signed(in_word[LANE_W*i +: LANE_W])) + OpW'($signed(input_off));
      flt_op[i] = OpW'($signed(flt_word[LANE_W*i +: LANE_W])) + OpW'($signed(filter_off));
      // Full 34-bit product; only the low 32 bits survive the truncated sum.
      prod[i]   = 32'(ProdW'(in_op[i]) * ProdW'(flt_op[i]));
      lane_sum  = lane_sum + prod[i];
    end
  end

endmodule

// File: rtl/cfu_mac_sequencer.sv
// CFU command/response sequencer that streams two local word buffers through
// the 4-lane SIMD MAC and returns the accumulated dot product.
// Ports:
//   clk, reset                 - clock, synchronous active-high reset
//   cmd_valid / cmd_ready      - command handshake (ready only when idle)
//   cmd_payload_function_id    - [9:3] opcode, [0] RUN chain flag
//   cmd_payload_inputs_0/1     - operands A and B
//   rsp_valid / rsp_ready      - response handshake
//   rsp_payload_outputs_0      - response word
module cfu_mac_sequencer
  import cfu_mac_pkg::*;
#(
  parameter int unsigned DEPTH  = 64,
  parameter int unsigned ADDR_W = 6
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [9:0]  cmd_payload_function_id,
  input  logic [31:0] cmd_payload_inputs_0,
  input  logic [31:0] cmd_payload_inputs_1,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_payload_outputs_0
);

  state_e             state_q, state_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic [15:0]        cnt_q, cnt_d;
  logic [31:0]        acc_q, acc_d;
  logic [31:0]        res_q, res_d;
  logic [OFF_W-1:0]   in_off_q, in_off_d;
  logic [OFF_W-1:0]   flt_off_q, flt_off_d;
  // High when the previous cycle issued a buffer read whose data is now valid.
  logic               rd_pend_q;

  logic [31:0]        in_buf  [DEPTH];
  logic [31:0]        flt_buf [DEPTH];
  logic [31:0]        in_rd_q, flt_rd_q;
  logic [31:0]        mac_sum;

  logic [OP_W-1:0]    opcode;
  logic               chain;
  logic               cmd_fire;
  logic [ADDR_W-1:0]  cmd_addr;
  logic [15:0]        run_len;
  logic               unused_bits;

  assign opcode      = cmd_payload_function_id[9:3];
  assign chain       = cmd_payload_function_id[0];
  assign cmd_fire    = cmd_valid && cmd_ready;
  assign cmd_addr    = cmd_payload_inputs_0[ADDR_W-1:0];
  assign run_len     = cmd_payload_inputs_1[15:0];
  assign unused_bits = ^{cmd_payload_function_id[2:1], cmd_payload_inputs_0[31:16]};

  assign cmd_ready             = (state_q == IDLE);
  assign rsp_valid             = (state_q == RESP);
  assign rsp_payload_outputs_0 = res_q;

  // Synchronous-read buffers, intentionally not reset. Writes only happen in
  // IDLE, so a read and a write never collide.
  always_ff @(posedge clk) begin
    if (cmd_fire && opcode == OP_WR_IN) begin
      in_buf[cmd_addr] <= cmd_payload_inputs_1;
    end
    if (cmd_fire && opcode == OP_WR_FLT) begin
      flt_buf[cmd_addr] <= cmd_payload_inputs_1;
    end
    in_rd_q  <= in_buf[addr_q];
    flt_rd_q <= flt_buf[addr_q];
  end

  simd_mac4 u_mac (
    .in_word    (in_rd_q),
    .flt_word   (flt_rd_q),
    .input_off  (in_off_q),
    .filter_off (flt_off_q),
    .lane_sum   (mac_sum)
  );

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    cnt_d     = cnt_q;
    acc_d     = acc_q;
    res_d     = res_q;
    in_off_d  = in_off_q;
    flt_off_d = flt_off_q;

    unique case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          res_d   = '0;
          state_d = RESP;
          case (opcode)
            OP_SET_OFF: begin
              in_off_d  = cmd_payload_inputs_0[OFF_W-1:0];
              flt_off_d = cmd_payload_inputs_1[OFF_W-1:0];
            end
            OP_RUN: begin
              acc_d = chain ? acc_q : '0;
              if (run_len == 16'd0) begin
                res_d = acc_d;
              end else begin
                addr_d  = cmd_addr;
                cnt_d   = run_len;
                state_d = FETCH;
              end
            end
            default: ;
          endcase
        end
      end
      FETCH: begin
        if (rd_pend_q) begin
          acc_d = acc_q + mac_sum;
        end
        addr_d = addr_q + 1'b1;
        cnt_d  = cnt_q - 16'd1;
        if (cnt_q == 16'd1) begin
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        acc_d   = acc_q + mac_sum;
        res_d   = acc_d;
        state_d = RESP;
      end
      RESP: begin
        if (rsp_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      addr_q    <= '0;
      cnt_q     <= '0;
      acc_q     <= '0;
      res_q     <= '0;
      in_off_q  <= '0;
      flt_off_q <= '0;
      rd_pend_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      cnt_q     <= cnt_d;
      acc_q     <= acc_d;
      res_q     <= res_d;
      in_off_q  <= in_off_d;
      flt_off_q <= flt_off_d;
      rd_pend_q <= (state_q == FETCH);
    end
  end

endmodule

// File: tb/tb_cfu_mac_sequencer.sv
// Self-checking bench for cfu_mac_sequencer: directed cases plus randomized
// RUNs against a dot-product reference model, checked by a scoreboard monitor.
module tb_cfu_mac_sequencer;

  localparam int unsigned DEPTH  = 64;
  localparam int unsigned ADDR_W = 6;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [9:0]  fid = '0;
  logic [31:0] in0 = '0;
  logic [31:0] in1 = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b1;
  logic [31:0] rsp_out;

  cfu_mac_sequencer #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) dut (
    .clk                     (clk),
    .reset                   (reset),
    .cmd_valid               (cmd_valid),
    .cmd_ready               (cmd_ready),
    .cmd_payload_function_id (fid),
    .cmd_payload_inputs_0    (in0),
    .cmd_payload_inputs_1    (in1),
    .rsp_valid               (rsp_valid),
    .rsp_ready               (rsp_ready),
    .rsp_payload_outputs_0   (rsp_out)
  );

  always #5 clk = ~clk;

  int          checks = 0;
  int          errors = 0;
  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Response backpressure: random or held at rdy_man; settles before negedge.
  bit bp_rand = 1'b0;
  bit rdy_man = 1'b1;
  always @(posedge clk) begin
    #2;
    rsp_ready = bp_rand ? 1'($urandom_range(0, 1)) : rdy_man;
  end

  // Reference model state.
  logic [31:0] in_m  [DEPTH];
  logic [31:0] flt_m [DEPTH];
  logic [31:0] acc_m = '0;
  int          io_m = 0;
  int          fo_m = 0;

  logic [31:0] exp_q [$];
  int unsigned lat_q [$];
  int unsigned acc_cyc_q [$];
  int unsigned resp_cnt = 0;

  function automatic logic [31:0] dot4(logic [31:0] a, logic [31:0] b, int io, int fo);
    longint s = 0;
    for (int i = 0; i < 4; i++) begin
      s += longint'($signed(a[8*i +: 8]) + io) * longint'($signed(b[8*i +: 8]) + fo);
    end
    return 32'(s);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Issue one command, update the model, and queue the expected response.
  task automatic send(input logic [6:0] op, input logic flag, input logic [31:0] a,
                      input logic [31:0] b, input bit expect_rsp);
    int          n = 0;
    logic [31:0] exp = '0;
    int unsigned len;
    int unsigned s;
    @(negedge clk);
    while (!cmd_ready && n < 400) begin
      @(negedge clk);
      n++;
    end
    if (!cmd_ready) begin
      chk("cmd_ready_timeout", {31'd0, cmd_ready}, 32'd1);
      return;
    end
    cmd_valid = 1'b1;
    fid = {op, 2'b00, flag};
    in0 = a;
    in1 = b;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    len = int'(b[15:0]);
    s   = int'(a[ADDR_W-1:0]);
    case (op)
      7'd0: begin
        io_m = int'($signed(a[15:0]));
        fo_m = int'($signed(b[15:0]));
      end
      7'd1: in_m[a[ADDR_W-1:0]] = b;
      7'd2: flt_m[a[ADDR_W-1:0]] = b;
      7'd3: begin
        exp = flag ? acc_m : 32'd0;
        for (int unsigned k = 0; k < len; k++) begin
          exp = exp + dot4(in_m[(s + k) % DEPTH], flt_m[(s + k) % DEPTH], io_m, fo_m);
        end
        acc_m = exp;
      end
      default: ;
    endcase
    if (expect_rsp) begin
      exp_q.push_back(exp);
      lat_q.push_back((op == 7'd3 && len != 0) ? len + 2 : 1);
      acc_cyc_q.push_back(cyc);
    end
  endtask

  // Scoreboard monitor: latency at the rising edge of rsp_valid, data at handshake.
  bit seen = 1'b0;
  always @(negedge clk) begin
    if (reset) begin
      seen = 1'b0;
    end else if (rsp_valid) begin
      if (!seen) begin
        seen = 1'b1;
        if (lat_q.size() == 0) chk("unexpected_rsp", {31'd0, rsp_valid}, 32'd0);
        else chk("latency", cyc - acc_cyc_q[0] + 1, lat_q[0]);
      end
      if (rsp_ready) begin
        seen = 1'b0;
        resp_cnt++;
        if (exp_q.size() != 0) begin
          chk("result", rsp_out, exp_q.pop_front());
          void'(lat_q.pop_front());
          void'(acc_cyc_q.pop_front());
        end
      end
    end
  end

  task automatic wait_drain(input string name);
    int n = 0;
    while (exp_q.size() != 0 && n < 1000) begin
      @(negedge clk);
      n++;
    end
    chk(name, exp_q.size(), 32'd0);
  endtask

  initial begin
    logic [31:0] held;
    int          n;
    int unsigned cnt0;

    repeat (3) @(posedge clk);
    #1;
    chk("reset_cmd_ready", {31'd0, cmd_ready}, 32'd1);
    chk("reset_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("reset_out", rsp_out, 32'd0);
    reset = 1'b0;

    // Unknown opcode, then the basic offset case and a wrapping run.
    send(7'd7, 1'b0, 32'h1234, 32'h5678, 1'b1);
    send(7'd0, 1'b0, 32'd128, 32'd0, 1'b1);
    send(7'd1, 1'b0, 32'd0, 32'h01020304, 1'b1);
    send(7'd2, 1'b0, 32'd0, 32'h01010101, 1'b1);
    send(7'd3, 1'b0, 32'd0, 32'd1, 1'b1);
    send(7'd0, 1'b0, 32'd0, 32'd0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      send(7'd1, 1'b0, (62 + i) % DEPTH, 32'hFFFFFFFF, 1'b1);
      send(7'd2, 1'b0, (62 + i) % DEPTH, 32'h02020202, 1'b1);
    end
    send(7'd3, 1'b0, 32'd62, 32'd3, 1'b1);
    send(7'd3, 1'b1, 32'd62, 32'd3, 1'b1);
    send(7'd3, 1'b0, 32'd0, 32'd0, 1'b1);
    wait_drain("drain_directed");

    // Randomized phase with response backpressure.
    bp_rand = 1'b1;
    send(7'd0, 1'b0, $urandom, $urandom, 1'b1);
    for (int i = 0; i < DEPTH; i++) begin
      send(7'd1, 1'b0, i, $urandom, 1'b1);
      send(7'd2, 1'b0, i, $urandom, 1'b1);
    end
    for (int i = 0; i < 25; i++) begin
      if (i % 6 == 5) send(7'd0, 1'b0, (i % 12 == 5) ? 32'h8000 : $urandom, $urandom, 1'b1);
      if (i % 4 == 3) send(7'd1, 1'b0, $urandom, $urandom, 1'b1);
      send(7'd3, 1'($urandom_range(0, 1)), $urandom, $urandom_range(0, 80), 1'b1);
    end
    wait_drain("drain_random");
    bp_rand = 1'b0;

    // Hold the response: output stable, commands ignored, single handshake.
    rdy_man = 1'b0;
    repeat (2) @(negedge clk);
    send(7'd3, 1'b0, 32'd62, 32'd3, 1'b1);
    held = exp_q[0];
    n = 0;
    while (!rsp_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("hold_rsp_seen", {31'd0, rsp_valid}, 32'd1);
    cnt0 = resp_cnt;
    cmd_valid = 1'b1;
    fid = {7'd1, 3'b000};
    in0 = 32'd5;
    in1 = 32'hDEADBEEF;
    repeat (5) begin
      @(negedge clk);
      chk("hold_out", rsp_out, held);
      chk("hold_valid", {31'd0, rsp_valid}, 32'd1);
      chk("hold_cmd_ready", {31'd0, cmd_ready}, 32'd0);
    end
    cmd_valid = 1'b0;
    rdy_man = 1'b1;
    wait_drain("hold_drain");
    repeat (4) @(negedge clk);
    chk("hold_single_handshake", resp_cnt - cnt0, 32'd1);
    send(7'd3, 1'b0, 32'd5, 32'd1, 1'b1);
    wait_drain("drain_hold");

    // Abort a RUN in its second FETCH cycle.
    send(7'd3, 1'b0, 32'd0, 32'd10, 1'b0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    chk("abort_cmd_ready", {31'd0, cmd_ready}, 32'd1);
    chk("abort_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("abort_out", rsp_out, 32'd0);
    reset = 1'b0;
    acc_m = '0;
    io_m = 0;
    fo_m = 0;
    repeat (15) @(negedge clk);
    chk("abort_no_rsp", {31'd0, rsp_valid}, 32'd0);
    send(7'd1, 1'b0, 32'd0, $urandom, 1'b1);
    send(7'd2, 1'b0, 32'd0, $urandom, 1'b1);
    send(7'd3, 1'b1, 32'd0, 32'd1, 1'b1);
    send(7'd0, 1'b0, 32'd5, 32'hFFF9, 1'b1);
    send(7'd3, 1'b0, 32'd0, 32'd1, 1'b1);
    wait_drain("drain_final");
    repeat (3) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
